job_dispatch_arb: RTL and testbench

JOB_DISPATCH_ARB -- requirements
Module: job_dispatch_arb

---
 rtl/jm_pkg.sv | 13 +
 rtl/jm_rr_arbiter.sv | 44 ++++
 rtl/job_dispatch_arb.sv | 187 ++++++++++++++++++
 tb/tb_job_dispatch_arb.sv | 326 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/jm_pkg.sv
// Shared constants and dispatch FSM state type for job_dispatch_arb.
package jm_pkg;

    localparam int ARB_RR    = 0;
    localparam int ARB_FIXED = 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_ISSUE = 2'd2
    } dsp_state_t;

endpackage

// File: rtl/jm_rr_arbiter.sv
// Round-robin / fixed-priority arbiter producing a one-hot grant from a request vector.
// The pointer moves past the granted index only when advance is high.
module jm_rr_arbiter #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         resetn,
    input  logic [N-1:0] req,
    input  logic         mode,
    input  logic         advance,
    output logic [N-1:0] grant
);

    localparam int PW = (N > 1) ? $clog2(N) : 1;

    logic [PW-1:0] ptr;
    logic [PW-1:0] base;
    logic [PW-1:0] gidx;
    logic          found;

    // Search starts at the pointer in round-robin mode, at index 0 in fixed mode.
    always_comb begin
        grant = '0;
        gidx  = '0;
        found = 1'b0;
        base  = mode ? '0 : ptr;
        for (int i = 0; i < N; i++) begin
            if (!found && req[(int'(base) + i) % N]) begin
                grant[(int'(base) + i) % N] = 1'b1;
                gidx  = PW'((int'(base) + i) % N);
                found = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ptr <= '0;
        end else if (advance && found && !mode) begin
            ptr <= (gidx == PW'(N - 1)) ? '0 : gidx + 1'b1;
        end
    end

endmodule

// File: rtl/job_dispatch_arb.sv
// Descriptor dispatcher to KERNEL_NUM engines with an independent completion return path.
// Optional per-kernel watchdog enabled by defining KERNEL_TIMEOUT_EN.
//
// state    | meaning
// ST_IDLE  | wait for descriptor and an eligible engine; pull and latch grant on exit
// ST_LOAD  | capture descriptor data into engine_data
// ST_ISSUE | pulse engine_start for the latched grant and mark it busy
module job_dispatch_arb
    import jm_pkg::*;
#(
    parameter int          HOST_DWIDTH    = 1024,
    parameter int          RETURN_WIDTH   = 41,
    parameter int          KERNEL_NUM     = 4,
    parameter int          ARB_MODE       = 0,
    parameter logic [31:0] TIMEOUT_CYCLES = 32'd65535
) (
    input  logic                               clk,
    input  logic                               resetn,
    input  logic                               dsc_ready_i,
    output logic                               dsc_pull_o,
    input  logic [HOST_DWIDTH-1:0]             dsc_data_i,
    input  logic [KERNEL_NUM-1:0]              kernel_enable_i,
    input  logic [KERNEL_NUM-1:0]              engine_ready,
    output logic [KERNEL_NUM-1:0]              engine_start,
    output logic [HOST_DWIDTH-1:0]             engine_data,
    input  logic [KERNEL_NUM-1:0]              complete_ready,
    output logic [KERNEL_NUM-1:0]              complete_accept,
    input  logic [RETURN_WIDTH*KERNEL_NUM-1:0] complete_data,
    input  logic                               complete_ready_i,
    output logic                               complete_push_o,
    output logic [RETURN_WIDTH-1:0]            return_data_o,
    output logic [KERNEL_NUM-1:0]              busy_o,
    output logic [$clog2(KERNEL_NUM+1)-1:0]    busy_cnt_o,
    output logic [KERNEL_NUM-1:0]              timeout_status_o,
    input  logic [KERNEL_NUM-1:0]              timeout_clear_i
);

    localparam int CW = $clog2(KERNEL_NUM + 1);

    dsp_state_t              state, state_nxt;
    logic [KERNEL_NUM-1:0]   busy, busy_nxt, eligible, timeout_status, to_fire;
    logic [KERNEL_NUM-1:0]   dsp_grant, grant_q, cmp_req, cmp_grant;
    logic [CW-1:0]           cnt_nxt;
    logic [RETURN_WIDTH-1:0] acc_word;
    logic                    hold, go;

    assign eligible = engine_ready & kernel_enable_i & ~busy & ~timeout_status;
    // Gate with resetn so the combinational pull cannot fire while reset is held.
    assign go = resetn & dsc_ready_i & (|eligible);

    jm_rr_arbiter #(.N(KERNEL_NUM)) u_dsp_arb (
        .clk     (clk),
        .resetn  (resetn),
        .req     (eligible),
        .mode    (ARB_MODE == ARB_FIXED),
        .advance (dsc_pull_o),
        .grant   (dsp_grant)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state <= ST_IDLE;
        else         state <= state_nxt;
    end

    always_comb begin
        state_nxt    = state;
        dsc_pull_o   = 1'b0;
        engine_start = '0;
        case (state)
            ST_IDLE: begin
                if (go) begin
                    state_nxt  = ST_LOAD;
                    dsc_pull_o = 1'b1;
                end
            end
            ST_LOAD:  state_nxt = ST_ISSUE;
            ST_ISSUE: begin
                state_nxt    = ST_IDLE;
                engine_start = grant_q;
            end
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            grant_q     <= '0;
            engine_data <= '0;
        end else begin
            if (dsc_pull_o)        grant_q     <= dsp_grant;
            if (state == ST_LOAD)  engine_data <= dsc_data_i;
        end
    end

    // Completion side: a single holding slot; no new accept while a word waits downstream.
    assign cmp_req         = hold ? '0 : (complete_ready & busy);
    assign complete_accept = cmp_grant;
    assign complete_push_o = hold & complete_ready_i;
    assign return_data_o   = acc_word_q_out();

    jm_rr_arbiter #(.N(KERNEL_NUM)) u_cmp_arb (
        .clk     (clk),
        .resetn  (resetn),
        .req     (cmp_req),
        .mode    (ARB_MODE == ARB_FIXED),
        .advance (|cmp_grant),
        .grant   (cmp_grant)
    );

    always_comb begin
        acc_word = '0;
        for (int k = 0; k < KERNEL_NUM; k++) begin
            if (cmp_grant[k]) acc_word = complete_data[k*RETURN_WIDTH +: RETURN_WIDTH];
        end
    end

    logic [RETURN_WIDTH-1:0] ret_q;

    function automatic logic [RETURN_WIDTH-1:0] acc_word_q_out();
        return ret_q;
    endfunction

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            hold  <= 1'b0;
            ret_q <= '0;
        end else if (complete_push_o) begin
            hold  <= 1'b0;
        end else if (|cmp_grant) begin
            hold  <= 1'b1;
            ret_q <= acc_word;
        end
    end

    // Set from ISSUE and clear from completion/timeout never target the same kernel.
    assign busy_nxt = (busy | engine_start) & ~complete_accept & ~to_fire;

    always_comb begin
        cnt_nxt = '0;
        for (int k = 0; k < KERNEL_NUM; k++) cnt_nxt = cnt_nxt + CW'(busy_nxt[k]);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            busy       <= '0;
            busy_cnt_o <= '0;
        end else begin
            busy       <= busy_nxt;
            busy_cnt_o <= cnt_nxt;
        end
    end

    assign busy_o           = busy;
    assign timeout_status_o = timeout_status;

`ifdef KERNEL_TIMEOUT_EN
    logic [31:0] to_cnt [KERNEL_NUM];

    // An accept in the same cycle wins over the watchdog.
    always_comb begin
        to_fire = '0;
        for (int k = 0; k < KERNEL_NUM; k++) begin
            to_fire[k] = busy[k] & ~complete_accept[k] & (to_cnt[k] == TIMEOUT_CYCLES - 32'd1);
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int k = 0; k < KERNEL_NUM; k++) to_cnt[k] <= '0;
            timeout_status <= '0;
        end else begin
            for (int k = 0; k < KERNEL_NUM; k++) begin
                if (engine_start[k] || complete_accept[k] || to_fire[k]) to_cnt[k] <= '0;
                else if (busy[k])                                         to_cnt[k] <= to_cnt[k] + 32'd1;
                if (to_fire[k])              timeout_status[k] <= 1'b1;
                else if (timeout_clear_i[k]) timeout_status[k] <= 1'b0;
            end
        end
    end
`else
    logic unused_timeout;
    assign unused_timeout = (^timeout_clear_i) ^ (^TIMEOUT_CYCLES);
    assign to_fire        = '0;
    assign timeout_status = '0;
`endif

endmodule

// File: tb/tb_job_dispatch_arb.sv
// Scoreboard bench for job_dispatch_arb: a round-robin and a fixed-priority instance.
module tb_job_dispatch_arb;

    localparam int KN = 4;
    localparam int HW = 32;
    localparam int RW = 41;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              resetn;
    logic              dsc_ready_r, dsc_ready_f;
    logic [HW-1:0]     dsc_data;
    logic [KN-1:0]     kernel_enable, engine_ready, complete_ready, timeout_clear;
    logic [RW*KN-1:0]  complete_data;
    logic              complete_ready_i;

    logic              pull_r, pull_f, push_r, push_f;
    logic [KN-1:0]     start_r, start_f, acc_r, acc_f, busy_r, busy_f, tos_r, tos_f;
    logic [HW-1:0]     edata_r, edata_f;
    logic [RW-1:0]     ret_r, ret_f;
    logic [2:0]        cnt_r, cnt_f;

    job_dispatch_arb #(.HOST_DWIDTH(HW), .RETURN_WIDTH(RW), .KERNEL_NUM(KN), .ARB_MODE(0),
                       .TIMEOUT_CYCLES(32'd16)) u_dut_rr (
        .clk(clk), .resetn(resetn), .dsc_ready_i(dsc_ready_r), .dsc_pull_o(pull_r),
        .dsc_data_i(dsc_data), .kernel_enable_i(kernel_enable), .engine_ready(engine_ready),
        .engine_start(start_r), .engine_data(edata_r), .complete_ready(complete_ready),
        .complete_accept(acc_r), .complete_data(complete_data), .complete_ready_i(complete_ready_i),
        .complete_push_o(push_r), .return_data_o(ret_r), .busy_o(busy_r), .busy_cnt_o(cnt_r),
        .timeout_status_o(tos_r), .timeout_clear_i(timeout_clear)
    );

    job_dispatch_arb #(.HOST_DWIDTH(HW), .RETURN_WIDTH(RW), .KERNEL_NUM(KN), .ARB_MODE(1),
                       .TIMEOUT_CYCLES(32'd16)) u_dut_fx (
        .clk(clk), .resetn(resetn), .dsc_ready_i(dsc_ready_f), .dsc_pull_o(pull_f),
        .dsc_data_i(dsc_data), .kernel_enable_i(kernel_enable), .engine_ready(engine_ready),
        .engine_start(start_f), .engine_data(edata_f), .complete_ready(complete_ready),
        .complete_accept(acc_f), .complete_data(complete_data), .complete_ready_i(complete_ready_i),
        .complete_push_o(push_f), .return_data_o(ret_f), .busy_o(busy_f), .busy_cnt_o(cnt_f),
        .timeout_status_o(tos_f), .timeout_clear_i(timeout_clear)
    );

    // The monitor follows one instance at a time.
    logic          mon_sel;
    logic          m_pull, m_push;
    logic [KN-1:0] m_start, m_acc;
    logic [HW-1:0] m_edata;
    logic [RW-1:0] m_ret;
    assign m_pull  = mon_sel ? pull_f  : pull_r;
    assign m_push  = mon_sel ? push_f  : push_r;
    assign m_start = mon_sel ? start_f : start_r;
    assign m_acc   = mon_sel ? acc_f   : acc_r;
    assign m_edata = mon_sel ? edata_f : edata_r;
    assign m_ret   = mon_sel ? ret_f   : ret_r;

    logic [KN-1:0] exp_mask_q[$];
    logic [HW-1:0] exp_data_q[$];
    logic [RW-1:0] exp_ret_q[$];
    int start_cyc_q[$], acc_cyc_q[$], push_cyc_q[$];
    int n_pull = 0, n_start = 0, n_acc = 0, n_push = 0;
    int n_chk = 0, n_pass = 0;
    int cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
        else n_pass++;
    endtask

    function automatic logic [RW-1:0] slice_val(input int k);
        return 41'h1_5A5A_0000 | RW'(k);
    endfunction

    // Descriptor responder and output scoreboard.
    initial begin
        forever begin
            @(negedge clk);
            if (m_pull) begin
                n_pull++;
                dsc_data = 32'hC0DE_0000 + 32'(n_pull);
                exp_data_q.push_back(dsc_data);
            end
            if (|m_start) begin
                n_start++;
                start_cyc_q.push_back(cyc);
                if (exp_mask_q.size() == 0 || exp_data_q.size() == 0) begin
                    check_eq("start_unexpected", 64'(m_start), 64'd0);
                end else begin
                    check_eq("start_mask", 64'(m_start), 64'(exp_mask_q.pop_front()));
                    check_eq("start_data", 64'(m_edata), 64'(exp_data_q.pop_front()));
                end
            end
            if (|m_acc) begin
                n_acc++;
                acc_cyc_q.push_back(cyc);
            end
            if (m_push) begin
                n_push++;
                push_cyc_q.push_back(cyc);
                if (exp_ret_q.size() == 0) check_eq("push_unexpected", 64'(m_ret), 64'd0);
                else                       check_eq("return_data", 64'(m_ret), 64'(exp_ret_q.pop_front()));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    task automatic wait_starts(input int target, input int budget);
        for (int i = 0; i < budget && n_start < target; i++) begin
            @(negedge clk); #1;
        end
        check_eq("wait_start", 64'(n_start), 64'(target));
    endtask

    task automatic wait_pushes(input int target, input int budget);
        for (int i = 0; i < budget && n_push < target; i++) begin
            @(negedge clk); #1;
        end
        check_eq("wait_push", 64'(n_push), 64'(target));
    endtask

    task automatic complete_kernel(input int k);
        int a0;
        a0 = n_acc;
        complete_ready[k] = 1'b1;
        exp_ret_q.push_back(slice_val(k));
        for (int i = 0; i < 20 && n_acc == a0; i++) begin
            @(negedge clk); #1;
        end
        check_eq("wait_accept", 64'(n_acc), 64'(a0 + 1));
        @(posedge clk); #1;
        complete_ready[k] = 1'b0;
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk) resetn = 1'b1;
        @(posedge clk); #1;
    endtask

    int s0, s1, a0, p0, bad, sc, tc;

    initial begin
        resetn = 1'b0;
        mon_sel = 1'b0;
        dsc_ready_r = 1'b0; dsc_ready_f = 1'b0; dsc_data = '0;
        kernel_enable = '0; engine_ready = '0; complete_ready = '0; timeout_clear = '0;
        complete_ready_i = 1'b0;
        for (int k = 0; k < KN; k++) complete_data[k*RW +: RW] = slice_val(k);

        #1;
        check_eq("rst_pull",   64'(pull_r),  64'd0);
        check_eq("rst_start",  64'(start_r), 64'd0);
        check_eq("rst_edata",  64'(edata_r), 64'd0);
        check_eq("rst_busy",   64'(busy_r),  64'd0);
        check_eq("rst_cnt",    64'(cnt_r),   64'd0);
        check_eq("rst_push",   64'(push_r),  64'd0);
        check_eq("rst_ret",    64'(ret_r),   64'd0);
        check_eq("rst_tos",    64'(tos_r),   64'd0);
        check_eq("rst_fx_pull", 64'(pull_f), 64'd0);
        do_reset();

        // Round-robin, all engines ready, four back-to-back descriptors.
        kernel_enable = 4'hF; engine_ready = 4'hF;
        exp_mask_q.push_back(4'b0001); exp_mask_q.push_back(4'b0010);
        exp_mask_q.push_back(4'b0100); exp_mask_q.push_back(4'b1000);
        s0 = n_start;
        dsc_ready_r = 1'b1;
        wait_starts(s0 + 4, 40);
        dsc_ready_r = 1'b0;
        if (start_cyc_q.size() >= s0 + 4)
            for (int i = 1; i < 4; i++)
                check_eq("start_gap", 64'(start_cyc_q[s0+i] - start_cyc_q[s0+i-1]), 64'd3);
        @(posedge clk); #1;
        check_eq("rr_busy", 64'(busy_r), 64'hF);
        check_eq("rr_busy_cnt", 64'(cnt_r), 64'd4);

        // Kernels 0 and 2 complete together while downstream stalls for 10 cycles.
        complete_ready = 4'b0101;
        exp_ret_q.push_back(slice_val(0)); exp_ret_q.push_back(slice_val(2));
        a0 = n_acc; p0 = n_push;
        repeat (10) @(posedge clk);
        #1;
        check_eq("stall_accepts", 64'(n_acc), 64'(a0 + 1));
        check_eq("stall_pushes",  64'(n_push), 64'(p0));
        complete_ready_i = 1'b1;
        wait_pushes(p0 + 2, 20);
        check_eq("stall_accepts2", 64'(n_acc), 64'(a0 + 2));
        if (acc_cyc_q.size() >= a0 + 2 && push_cyc_q.size() >= p0 + 1) begin
            check_eq("first_push_delay", 64'(push_cyc_q[p0] - acc_cyc_q[a0]), 64'd10);
            check_eq("accept_after_push", 64'(acc_cyc_q[a0+1] - push_cyc_q[p0]), 64'd1);
        end
        @(posedge clk); #1;
        complete_ready = '0;
        check_eq("busy_after_02", 64'(busy_r), 64'b1010);
        // Completion pointer sits at 3 after granting 2, so kernel 3 goes before 1.
        complete_ready = 4'b1010;
        exp_ret_q.push_back(slice_val(3)); exp_ret_q.push_back(slice_val(1));
        wait_pushes(p0 + 4, 20);
        @(posedge clk); #1;
        complete_ready = '0;
        check_eq("busy_drained", 64'(busy_r), 64'd0);
        check_eq("cnt_drained",  64'(cnt_r),  64'd0);

        // Fixed priority with kernels 1 and 3 enabled.
        mon_sel = 1'b1;
        kernel_enable = 4'b1010;
        exp_mask_q.push_back(4'b0010); exp_mask_q.push_back(4'b1000);
        s0 = n_start;
        dsc_ready_f = 1'b1;
        wait_starts(s0 + 2, 30);
        @(posedge clk); #1;
        check_eq("fx_busy", 64'(busy_f), 64'b1010);
        exp_mask_q.push_back(4'b0010);
        complete_kernel(1);
        wait_starts(s0 + 3, 30);
        dsc_ready_f = 1'b0;
        @(posedge clk); #1;
        check_eq("fx_busy2", 64'(busy_f), 64'b1010);
        mon_sel = 1'b0;

        // Nothing enabled: no pulls from either instance.
        kernel_enable = '0;
        dsc_ready_r = 1'b1; dsc_ready_f = 1'b1;
        bad = 0;
        repeat (20) begin
            @(negedge clk);
            if (pull_r || pull_f) bad++;
        end
        check_eq("no_enable_pull", 64'(bad), 64'd0);
        dsc_ready_r = 1'b0; dsc_ready_f = 1'b0;
        @(posedge clk); #1;

        // Reset asserted during LOAD with kernels 0 and 1 busy.
        kernel_enable = 4'hF;
        exp_mask_q.push_back(4'b0001); exp_mask_q.push_back(4'b0010);
        p0 = n_pull; s0 = n_start;
        dsc_ready_r = 1'b1;
        for (int i = 0; i < 30 && n_pull < p0 + 3; i++) begin
            @(negedge clk); #1;
        end
        check_eq("third_pull", 64'(n_pull), 64'(p0 + 3));
        check_eq("starts_before_rst", 64'(n_start), 64'(s0 + 2));
        @(posedge clk); #1;
        check_eq("busy_in_load", 64'(busy_r), 64'b0011);
        resetn = 1'b0;
        dsc_ready_r = 1'b0;
        #1;
        check_eq("arst_edata", 64'(edata_r), 64'd0);
        check_eq("arst_ret",   64'(ret_r),   64'd0);
        check_eq("arst_busy",  64'(busy_r),  64'd0);
        check_eq("arst_cnt",   64'(cnt_r),   64'd0);
        check_eq("arst_pull",  64'(pull_r),  64'd0);
        @(posedge clk); #1;
        check_eq("arst_start", 64'(start_r), 64'd0);
        @(negedge clk) resetn = 1'b1;
        exp_data_q.delete();
        exp_mask_q.delete();
        s1 = n_start;
        repeat (10) @(posedge clk);
        #1;
        check_eq("no_start_after_rst", 64'(n_start), 64'(s1));
        exp_mask_q.push_back(4'b0001);
        dsc_ready_r = 1'b1;
        wait_starts(s1 + 1, 20);
        dsc_ready_r = 1'b0;

`ifdef KERNEL_TIMEOUT_EN
        // Kernel 2 never completes: watchdog fires after 16 busy cycles.
        do_reset();
        kernel_enable = 4'b0100;
        exp_mask_q.push_back(4'b0100);
        s0 = n_start;
        dsc_ready_r = 1'b1;
        wait_starts(s0 + 1, 20);
        dsc_ready_r = 1'b0;
        sc = (start_cyc_q.size() > s0) ? start_cyc_q[s0] : 0;
        tc = 0;
        for (int i = 0; i < 40 && !tos_r[2]; i++) begin
            @(negedge clk); #1;
            tc = cyc;
        end
        check_eq("timeout_latency", 64'(tc - sc), 64'd17);
        check_eq("timeout_status", 64'(tos_r), 64'b0100);
        check_eq("timeout_busy", 64'(busy_r), 64'd0);
        p0 = n_pull;
        dsc_ready_r = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        check_eq("timeout_skip", 64'(n_pull), 64'(p0));
        exp_mask_q.push_back(4'b0100);
        timeout_clear = 4'b0100;
        @(posedge clk); #1;
        timeout_clear = '0;
        check_eq("timeout_cleared", 64'(tos_r), 64'd0);
        wait_starts(s0 + 2, 20);
        dsc_ready_r = 1'b0;
`else
        // Without the watchdog a stuck kernel stays busy and status stays low.
        repeat (40) @(posedge clk);
        #1;
        check_eq("no_timeout_status", 64'(tos_r), 64'd0);
        check_eq("stuck_busy", 64'(busy_r), 64'b0001);
        timeout_clear = 4'hF;
        @(posedge clk); #1;
        timeout_clear = '0;
        check_eq("clear_ignored_busy", 64'(busy_r), 64'b0001);
        check_eq("clear_ignored_tos", 64'(tos_r), 64'd0);
`endif

        repeat (5) @(posedge clk);
        check_eq("mask_q_empty", 64'(exp_mask_q.size()), 64'd0);
        check_eq("ret_q_empty",  64'(exp_ret_q.size()),  64'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
